// File: rtl/register_file_sb.sv
// Register file with write-to-read bypass, busy scoreboard and post-reset clear sequencer.
// Register 0 can optionally be hardwired to zero.
module register_file_sb #(
    parameter int DataWidth  = 16,
    parameter int SelectSize = 3,
    parameter int ZeroReg    = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  REG_WE,
    input  logic [SelectSize-1:0] REG_Dst,
    input  logic [DataWidth-1:0]  DIn,
    input  logic [SelectSize-1:0] REG_Src1,
    input  logic [SelectSize-1:0] REG_Src2,
    input  logic                  REG_Claim,
    input  logic [SelectSize-1:0] REG_ClaimSel,
    output logic [DataWidth-1:0]  SRC1,
    output logic [DataWidth-1:0]  SRC2,
    output logic                  Src1_Busy,
    output logic                  Src2_Busy,
    output logic                  Ready
);

    localparam int Depth = 1 << SelectSize;
    localparam logic [SelectSize-1:0] LastIdx = SelectSize'(Depth - 1);

    // state | meaning
    // CLEAR | zeroing reg[cnt_q], one register per edge
    // RUN   | normal operation: writes, claims, reads
    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [SelectSize-1:0]   cnt_q, cnt_d;
    logic [Depth-1:0]        busy_q, busy_d;
    logic [DataWidth-1:0]    regs_q [Depth];

    logic                    wr_en;
    logic [SelectSize-1:0]   wr_addr;
    logic [DataWidth-1:0]    wr_data;
    logic                    run_wr;
    logic                    run_claim;
    logic                    byp1, byp2;
    logic                    zero1, zero2;

    assign Ready = (state_q == RUN);

    // Writes and claims aimed at a hardwired-zero register 0 are dropped here.
    assign run_wr    = Ready && !REG_WE && !((ZeroReg != 0) && (REG_Dst == '0));
    assign run_claim = Ready && REG_Claim && !((ZeroReg != 0) && (REG_ClaimSel == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        wr_addr = REG_Dst;
        wr_data = DIn;
        if (Reset) begin
            state_d = CLEAR;
            cnt_d   = '0;
            busy_d  = '0;
        end else if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            cnt_d   = cnt_q + SelectSize'(1);
            if (cnt_q == LastIdx) begin
                state_d = RUN;
            end
        end else begin
            wr_en = run_wr;
            if (run_wr) begin
                busy_d[REG_Dst] = 1'b0;
            end
            // Claim after write: a new producer outranks the value landing now.
            if (run_claim) begin
                busy_d[REG_ClaimSel] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        busy_q  <= busy_d;
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign zero1 = (ZeroReg != 0) && (REG_Src1 == '0);
    assign zero2 = (ZeroReg != 0) && (REG_Src2 == '0);
    assign byp1  = !REG_WE && (REG_Dst == REG_Src1);
    assign byp2  = !REG_WE && (REG_Dst == REG_Src2);

    always_comb begin
        SRC1      = '0;
        SRC2      = '0;
        Src1_Busy = 1'b0;
        Src2_Busy = 1'b0;
        if (Ready) begin
            if (!zero1) begin
                SRC1      = byp1 ? DIn : regs_q[REG_Src1];
                Src1_Busy = busy_q[REG_Src1] && !byp1;
            end
            if (!zero2) begin
                SRC2      = byp2 ? DIn : regs_q[REG_Src2];
                Src2_Busy = busy_q[REG_Src2] && !byp2;
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one default instance and one with ZeroReg=1,
// driven by the same inputs.
module tb_register_file_sb;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        REG_WE;
    logic [2:0]  REG_Dst;
    logic [15:0] DIn;
    logic [2:0]  REG_Src1;
    logic [2:0]  REG_Src2;
    logic        REG_Claim;
    logic [2:0]  REG_ClaimSel;
    logic [15:0] SRC1, SRC2, z_SRC1, z_SRC2;
    logic        Src1_Busy, Src2_Busy, Ready;
    logic        z_Src1_Busy, z_Src2_Busy, z_Ready;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    register_file_sb #(.DataWidth(16), .SelectSize(3), .ZeroReg(0)) dut (
        .Clk(Clk), .Reset(Reset), .REG_WE(REG_WE), .REG_Dst(REG_Dst), .DIn(DIn),
        .REG_Src1(REG_Src1), .REG_Src2(REG_Src2), .REG_Claim(REG_Claim),
        .REG_ClaimSel(REG_ClaimSel), .SRC1(SRC1), .SRC2(SRC2),
        .Src1_Busy(Src1_Busy), .Src2_Busy(Src2_Busy), .Ready(Ready)
    );

    register_file_sb #(.DataWidth(16), .SelectSize(3), .ZeroReg(1)) zdut (
        .Clk(Clk), .Reset(Reset), .REG_WE(REG_WE), .REG_Dst(REG_Dst), .DIn(DIn),
        .REG_Src1(REG_Src1), .REG_Src2(REG_Src2), .REG_Claim(REG_Claim),
        .REG_ClaimSel(REG_ClaimSel), .SRC1(z_SRC1), .SRC2(z_SRC2),
        .Src1_Busy(z_Src1_Busy), .Src2_Busy(z_Src2_Busy), .Ready(z_Ready)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; REG_WE = 1'b1; REG_Dst = '0; DIn = '0;
        REG_Src1 = '0; REG_Src2 = '0; REG_Claim = 1'b0; REG_ClaimSel = '0;
        tick();
        check("rst_ready", Ready, 0);
        check("rst_src1", SRC1, 0);
        check("rst_src2", SRC2, 0);
        check("rst_busy1", Src1_Busy, 0);
        check("rst_busy2", Src2_Busy, 0);

        // Clear phase with writes and claims hammering; all must be ignored.
        Reset = 1'b0; REG_WE = 1'b0; REG_Dst = 3'd0; DIn = 16'hDEAD;
        REG_Claim = 1'b1; REG_ClaimSel = 3'd1; REG_Src1 = 3'd0; REG_Src2 = 3'd1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("clr_ready_%0d", i), Ready, 0);
            check($sformatf("clr_src1_%0d", i), SRC1, 0);
            tick();
        end
        check("clr_done_ready", Ready, 1);
        check("clr_done_zready", z_Ready, 1);
        REG_WE = 1'b1; REG_Claim = 1'b0;
        for (int i = 0; i < 8; i++) begin
            REG_Src1 = 3'(i); REG_Src2 = 3'(i);
            #1;
            check($sformatf("clr_reg_%0d", i), SRC1, 0);
            check($sformatf("clr_busy_%0d", i), Src2_Busy, 0);
        end

        // Writes and bypass.
        REG_WE = 1'b0; REG_Dst = 3'd0; DIn = 16'h00A0;
        tick();
        REG_Dst = 3'd1; DIn = 16'h000A; REG_Src1 = 3'd1; REG_Src2 = 3'd0;
        #1;
        check("byp_src1", SRC1, 16'h000A);
        check("st_src2_reg0", SRC2, 16'h00A0);
        check("z_src2_reg0", z_SRC2, 16'h0000);
        tick();
        REG_WE = 1'b1;
        #1;
        check("st_src1_reg1", SRC1, 16'h000A);

        // Scoreboard: claim then write.
        REG_Claim = 1'b1; REG_ClaimSel = 3'd3; REG_Src1 = 3'd3;
        #1;
        check("claim_not_yet", Src1_Busy, 0);
        tick();
        REG_Claim = 1'b0;
        #1;
        check("claim_busy", Src1_Busy, 1);
        REG_WE = 1'b0; REG_Dst = 3'd3; DIn = 16'h1234; REG_Src2 = 3'd3;
        #1;
        check("wr_busy_drop", Src1_Busy, 0);
        check("wr_byp1", SRC1, 16'h1234);
        check("wr_byp2", SRC2, 16'h1234);
        tick();
        REG_WE = 1'b1;
        #1;
        check("wr_busy_after", Src1_Busy, 0);
        check("wr_st_after", SRC1, 16'h1234);

        // Claim and write of the same register: data lands, busy stays set.
        REG_WE = 1'b0; REG_Dst = 3'd5; DIn = 16'hBEEF;
        REG_Claim = 1'b1; REG_ClaimSel = 3'd5; REG_Src2 = 3'd5;
        #1;
        check("cw_busy_now", Src2_Busy, 0);
        tick();
        REG_WE = 1'b1; REG_Claim = 1'b0; DIn = 16'h0000;
        #1;
        check("cw_data", SRC2, 16'hBEEF);
        check("cw_busy", Src2_Busy, 1);

        // Register 0: hardwired in zdut, ordinary in dut.
        REG_WE = 1'b0; REG_Dst = 3'd0; DIn = 16'hFFFF;
        REG_Claim = 1'b1; REG_ClaimSel = 3'd0; REG_Src1 = 3'd0;
        #1;
        check("z0_src1_now", z_SRC1, 16'h0000);
        check("z0_busy_now", z_Src1_Busy, 0);
        check("r0_byp_now", SRC1, 16'hFFFF);
        tick();
        REG_WE = 1'b1; REG_Claim = 1'b0; DIn = 16'h0000;
        #1;
        check("z0_src1_after", z_SRC1, 16'h0000);
        check("z0_busy_after", z_Src1_Busy, 0);
        check("r0_src1_after", SRC1, 16'hFFFF);
        check("r0_busy_after", Src1_Busy, 1);

        // Reset in RUN re-clears contents and scoreboard.
        REG_WE = 1'b0; REG_Dst = 3'd2; DIn = 16'h5555;
        tick();
        REG_WE = 1'b1; REG_Claim = 1'b1; REG_ClaimSel = 3'd4;
        tick();
        REG_Claim = 1'b0; REG_Src1 = 3'd2; REG_Src2 = 3'd4;
        #1;
        check("pre_rst_reg2", SRC1, 16'h5555);
        check("pre_rst_busy4", Src2_Busy, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rr_ready_drop", Ready, 0);
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr_ready_%0d", i), Ready, 0);
            tick();
        end
        check("rr_ready_up", Ready, 1);
        check("rr_reg2", SRC1, 16'h0000);
        check("rr_busy4", Src2_Busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the CPU register file: `2**SelectSize` registers of `DataWidth` bits, one write port and two asynchronous read ports.

- Adds same-cycle write-to-read bypass, an optional hardwired-zero register 0, a per-register busy scoreboard for pipelined producers, and a post-reset clear sequencer that zeroes every register one per cycle.
- Sits between the instruction decoder (source/destination selects, claims) and the ALU/writeback path.

## Interface
Parameters:
- DataWidth, 16, register and data bus width
- SelectSize, 3, select width; Depth = 2**SelectSize registers
- ZeroReg, 0, 1 = register 0 reads as 0, ignores writes, never busy

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  reset, synchronous, active-high
- REG_WE  in  1  write enable, active-low
- REG_Dst  in  SelectSize  write destination select
- DIn  in  DataWidth  write data
- REG_Src1  in  SelectSize  read port 1 select
- REG_Src2  in  SelectSize  read port 2 select
- REG_Claim  in  1  active-high; mark REG_ClaimSel busy (pending producer)
- REG_ClaimSel  in  SelectSize  register being claimed
- SRC1  out  DataWidth  read port 1 data (combinational)
- SRC2  out  DataWidth  read port 2 data (combinational)
- Src1_Busy  out  1  register selected by REG_Src1 has a pending producer
- Src2_Busy  out  1  same for REG_Src2
- Ready  out  1  clear sequence done; file accepts writes and claims

## Operation
- State machine: CLEAR, RUN.
  - Reset high at an edge: state=CLEAR, clear counter=0, all busy bits=0. Register contents are not modified while Reset is high.
  - In CLEAR with Reset low: each edge writes 0 to reg[counter] and increments the counter.
  - On the edge that clears reg[Depth-1]: state=RUN.
  - RUN persists until Reset.
- Ready = (state==RUN), registered.
- While Ready=0:
  - REG_WE and REG_Claim are ignored.
  - SRC1/SRC2 read 0.
  - Src1_Busy/Src2_Busy read 0.
- Write in RUN: REG_WE=0 at an edge gives reg[REG_Dst] <= DIn and clears busy[REG_Dst].
- Claim in RUN: REG_Claim=1 at an edge sets busy[REG_ClaimSel].
- Claim and write to the same register in one cycle: the data is written and busy ends set (claim wins; this is the new producer).
- Read (RUN):
  - SRCx = DIn if REG_WE=0 and REG_Dst==REG_Srcx (bypass).
  - Otherwise SRCx = reg[REG_Srcx].
  - Both ports may select the same register and both bypass.
- Busy (RUN): Srcx_Busy = busy[REG_Srcx] AND NOT (REG_WE=0 AND REG_Dst==REG_Srcx). A write in flight to that register supplies the data.
- ZeroReg=1:
  - Reads of register 0 return 0 with no bypass.
  - Writes and claims to register 0 are discarded.
  - Src busy for register 0 is always 0.
- No arithmetic beyond the clear counter. The counter is SelectSize bits wide and does not wrap in use, because the transition to RUN occurs at Depth-1.

## Timing
- Reset values: Ready=0, all busy=0, SRC1=SRC2=0, Src1_Busy=Src2_Busy=0.
- Clear latency: Reset is deasserted before edge k. Registers clear on edges k..k+Depth-1. Ready=1 after edge k+Depth-1, i.e. Depth cycles after the first Reset-low edge.
- Reset asserted mid-clear or mid-run:
  - The next edge restarts CLEAR at counter 0.
  - Busy bits clear.
  - Partially cleared registers are re-cleared.
- Write-to-read latency:
  - 0 cycles via bypass, from the same cycle.
  - From the stored copy, visible from the edge onward.
- Claim-to-busy latency: 1 edge.
- Write-clears-busy: the combinational busy output drops in the write cycle; the stored bit clears at the edge.

## Test plan
- Reset 1 cycle, DataWidth=16, SelectSize=3: Ready low for exactly 8 edges, then high; all 8 registers read 0000; writes attempted during CLEAR have no effect.
- Writes: write reg0<-00A0 then reg1<-000A with REG_WE=0 → SRC1 on reg1 shows 000A in the write cycle (bypass) and after the edge; SRC2 on reg0 reads 00A0.
- Scoreboard: claim reg3 → next cycle Src1_Busy=1 for REG_Src1=3. Write reg3<-1234 → Src1_Busy=0 and SRC1=1234 in that cycle; busy stays 0 after the edge.
- Simultaneous claim and write of reg5 with DIn=BEEF → after the edge reg5=BEEF and Src2_Busy=1 for REG_Src2=5.
- ZeroReg=1: write reg0<-FFFF and claim reg0 → SRC1 on reg0 reads 0000 in that cycle and after; Src1_Busy=0.
- Assert Reset during RUN after writing reg2=5555 and claiming reg4 → Ready drops next edge; after 8 clear edges reg2 reads 0000 and reg4 is not busy.
